// File: rtl/graphics_package.sv
// Shared shape-layer types: drawing modes, the per-shape descriptor and
// span helpers used by the hit test.
package graphics_package;

    localparam int SHAPE_COORD_W = 12;
    localparam int SHAPE_COLOR_W = 24;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_FILL    = 2'd1,
        MODE_OUTLINE = 2'd2,
        MODE_BLINK   = 2'd3
    } shape_mode_t;

    typedef struct packed {
        logic [SHAPE_COORD_W-1:0] x;
        logic [SHAPE_COORD_W-1:0] y;
        logic [SHAPE_COORD_W-1:0] w;
        logic [SHAPE_COORD_W-1:0] h;
        shape_mode_t              mode;
        logic [SHAPE_COLOR_W-1:0] color;
    } shape_t;

    localparam shape_t SHAPE_RESET = '0;

    localparam logic [SHAPE_COORD_W:0] ONE_EXT = {{SHAPE_COORD_W{1'b0}}, 1'b1};

    // Last covered coordinate, one bit wider so a span ending at the top of
    // the coordinate range cannot wrap back to zero.
    function automatic logic [SHAPE_COORD_W:0] span_last(
        input logic [SHAPE_COORD_W-1:0] start,
        input logic [SHAPE_COORD_W-1:0] len
    );
        return {1'b0, start} + {1'b0, len} - ONE_EXT;
    endfunction

    function automatic logic span_hit(
        input logic [SHAPE_COORD_W-1:0] pos,
        input logic [SHAPE_COORD_W-1:0] start,
        input logic [SHAPE_COORD_W-1:0] len
    );
        return (len != '0) && (pos >= start) && ({1'b0, pos} <= span_last(start, len));
    endfunction

    function automatic logic span_edge(
        input logic [SHAPE_COORD_W-1:0] pos,
        input logic [SHAPE_COORD_W-1:0] start,
        input logic [SHAPE_COORD_W-1:0] len
    );
        return (pos == start) || ({1'b0, pos} == span_last(start, len));
    endfunction

endpackage

// File: rtl/shape_layer_compositor_hit_test.sv
// Combinational hit test of one pixel position against one shape,
// including mode handling (outline border and blink gating).
module shape_hit_test
    import graphics_package::*;
(
    input  logic [SHAPE_COORD_W-1:0] i_pos_x,
    input  logic [SHAPE_COORD_W-1:0] i_pos_y,
    input  shape_t                   i_shape,
    input  logic                     i_blink_phase,
    output logic                     o_hit
);

    logic w_inside;
    logic w_on_edge;

    assign w_inside  = span_hit(i_pos_x, i_shape.x, i_shape.w)
                     && span_hit(i_pos_y, i_shape.y, i_shape.h);
    assign w_on_edge = span_edge(i_pos_x, i_shape.x, i_shape.w)
                     || span_edge(i_pos_y, i_shape.y, i_shape.h);

    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned and infers a latch.
    always_comb begin
        o_hit = 1'b0;
        unique case (i_shape.mode)
            MODE_OFF:     o_hit = 1'b0;
            MODE_FILL:    o_hit = w_inside;
            MODE_OUTLINE: o_hit = w_inside && w_on_edge;
            MODE_BLINK:   o_hit = w_inside && i_blink_phase;
            default:      o_hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/shape_layer_compositor.sv
// Overlays up to N_SHAPES rectangles on a video stream. Configuration goes
// to a shadow set that becomes active on the vsync rising edge.
module shape_layer_compositor
    import graphics_package::*;
#(
    parameter int N_SHAPES   = 4,
    parameter int COORD_W    = 12,
    parameter int COLOR_W    = 24,
    parameter int BLINK_LOG2 = 5
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic [COORD_W-1:0]   pos_x,
    input  logic [COORD_W-1:0]   pos_y,
    input  logic                 de_in,
    input  logic                 hsync_in,
    input  logic                 vsync_in,

    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [(N_SHAPES > 1 ? $clog2(N_SHAPES) : 1)-1:0] cfg_idx,
    input  logic [COORD_W-1:0]   cfg_x,
    input  logic [COORD_W-1:0]   cfg_y,
    input  logic [COORD_W-1:0]   cfg_w,
    input  logic [COORD_W-1:0]   cfg_h,
    input  logic [1:0]           cfg_mode,
    input  logic [COLOR_W-1:0]   cfg_color,

    input  logic [COLOR_W-1:0]   bg_color,
    output logic [COLOR_W-1:0]   rgb_out,
    output logic                 de_out,
    output logic                 hsync_out,
    output logic                 vsync_out
);

    localparam int IDX_W = (N_SHAPES > 1) ? $clog2(N_SHAPES) : 1;
    localparam logic [BLINK_LOG2:0] FRAME_STEP = {{BLINK_LOG2{1'b0}}, 1'b1};

    shape_t                  r_shadow [N_SHAPES];
    shape_t                  r_active [N_SHAPES];
    logic [BLINK_LOG2:0]     r_frame_cnt;

    logic [N_SHAPES-1:0]     r_hit;
    logic                    r_de1, r_hs1, r_vs1;
    logic [COLOR_W-1:0]      r_rgb;
    logic                    r_de2, r_hs2, r_vs2;

    logic                    w_commit;
    logic                    w_idx_ok;
    shape_t                  w_cfg_shape;
    logic [SHAPE_COORD_W-1:0] w_pos_x, w_pos_y;
    logic [N_SHAPES-1:0]     w_hit;
    logic [COLOR_W-1:0]      w_rgb_next;

    // r_vs1 doubles as the previous-cycle vsync for edge detection.
    assign w_commit  = vsync_in && !r_vs1;
    assign cfg_ready = !rst && !w_commit;
    assign w_idx_ok  = (32'(cfg_idx) < 32'(N_SHAPES));

    always_comb begin
        w_cfg_shape       = SHAPE_RESET;
        w_cfg_shape.x     = SHAPE_COORD_W'(cfg_x);
        w_cfg_shape.y     = SHAPE_COORD_W'(cfg_y);
        w_cfg_shape.w     = SHAPE_COORD_W'(cfg_w);
        w_cfg_shape.h     = SHAPE_COORD_W'(cfg_h);
        w_cfg_shape.mode  = shape_mode_t'(cfg_mode);
        w_cfg_shape.color = SHAPE_COLOR_W'(cfg_color);
    end

    // NOTE: the shape tables are small register arrays, not RAM, so they are
    // cleared by reset like any other state; sequential state always uses <=.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_SHAPES; i++) begin
                r_shadow[i] <= SHAPE_RESET;
                r_active[i] <= SHAPE_RESET;
            end
            r_frame_cnt <= '0;
        end else begin
            if (w_commit) begin
                for (int i = 0; i < N_SHAPES; i++) begin
                    r_active[i] <= r_shadow[i];
                end
                r_frame_cnt <= r_frame_cnt + FRAME_STEP;
            end
            if (cfg_valid && cfg_ready && w_idx_ok) begin
                r_shadow[cfg_idx] <= w_cfg_shape;
            end
        end
    end

    assign w_pos_x = SHAPE_COORD_W'(pos_x);
    assign w_pos_y = SHAPE_COORD_W'(pos_y);

    for (genvar g = 0; g < N_SHAPES; g++) begin : g_shape
        shape_hit_test u_hit_test (
            .i_pos_x       (w_pos_x),
            .i_pos_y       (w_pos_y),
            .i_shape       (r_active[g]),
            .i_blink_phase (r_frame_cnt[BLINK_LOG2]),
            .o_hit         (w_hit[g])
        );
    end

    // Walk from the highest index down so the lowest-index hit lands last.
    always_comb begin
        w_rgb_next = '0;
        if (r_de1) begin
            w_rgb_next = bg_color;
            for (int i = N_SHAPES - 1; i >= 0; i--) begin
                if (r_hit[i]) begin
                    w_rgb_next = COLOR_W'(r_active[i].color);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit <= '0;
            r_de1 <= 1'b0;
            r_hs1 <= 1'b0;
            r_vs1 <= 1'b0;
            r_rgb <= '0;
            r_de2 <= 1'b0;
            r_hs2 <= 1'b0;
            r_vs2 <= 1'b0;
        end else begin
            r_hit <= w_hit;
            r_de1 <= de_in;
            r_hs1 <= hsync_in;
            r_vs1 <= vsync_in;
            r_rgb <= w_rgb_next;
            r_de2 <= r_de1;
            r_hs2 <= r_hs1;
            r_vs2 <= r_vs1;
        end
    end

    assign rgb_out   = r_rgb;
    assign de_out    = r_de2;
    assign hsync_out = r_hs2;
    assign vsync_out = r_vs2;

endmodule

// File: tb/tb_shape_layer_compositor.sv
// Directed bench for shape_layer_compositor: fill, deferred commit, priority
// and outline, coordinate boundaries, mid-frame reset and blink.
module tb_shape_layer_compositor;

    localparam int N_SHAPES   = 4;
    localparam int COORD_W    = 12;
    localparam int COLOR_W    = 24;
    localparam int BLINK_LOG2 = 1;

    localparam logic [23:0] BG    = 24'h123456;
    localparam logic [23:0] RED   = 24'hFF0000;
    localparam logic [23:0] GREEN = 24'h00FF00;
    localparam logic [23:0] BLUE  = 24'h0000FF;
    localparam logic [23:0] WHITE = 24'hFFFFFF;
    localparam logic [23:0] GREY  = 24'h555555;
    localparam logic [23:0] CYAN  = 24'h00FFFF;

    logic               clk = 1'b0;
    logic               rst;
    logic [COORD_W-1:0] pos_x, pos_y;
    logic               de_in, hsync_in, vsync_in;
    logic               cfg_valid, cfg_ready;
    logic [1:0]         cfg_idx;
    logic [COORD_W-1:0] cfg_x, cfg_y, cfg_w, cfg_h;
    logic [1:0]         cfg_mode;
    logic [COLOR_W-1:0] cfg_color, bg_color, rgb_out;
    logic               de_out, hsync_out, vsync_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    shape_layer_compositor #(
        .N_SHAPES   (N_SHAPES),
        .COORD_W    (COORD_W),
        .COLOR_W    (COLOR_W),
        .BLINK_LOG2 (BLINK_LOG2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .de_in     (de_in),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_idx   (cfg_idx),
        .cfg_x     (cfg_x),
        .cfg_y     (cfg_y),
        .cfg_w     (cfg_w),
        .cfg_h     (cfg_h),
        .cfg_mode  (cfg_mode),
        .cfg_color (cfg_color),
        .bg_color  (bg_color),
        .rgb_out   (rgb_out),
        .de_out    (de_out),
        .hsync_out (hsync_out),
        .vsync_out (vsync_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cfg_write(input logic [1:0] idx, input logic [11:0] x, input logic [11:0] y,
                             input logic [11:0] w, input logic [11:0] h,
                             input logic [1:0] mode, input logic [23:0] color);
        int waited;
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_idx   = idx;
        cfg_x     = x;
        cfg_y     = y;
        cfg_w     = w;
        cfg_h     = h;
        cfg_mode  = mode;
        cfg_color = color;
        waited    = 0;
        while (!cfg_ready && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (!cfg_ready) check("cfg_ready_timeout", {31'b0, cfg_ready}, 32'd1);
        @(posedge clk);
        #1 cfg_valid = 1'b0;
    endtask

    task automatic vsync_pulse();
        @(negedge clk);
        vsync_in = 1'b1;
        #1 check("commit_cfg_ready_low", {31'b0, cfg_ready}, 32'd0);
        @(negedge clk);
        vsync_in = 1'b0;
    endtask

    task automatic pixel(input string tag, input logic [11:0] x, input logic [11:0] y,
                         input logic de, input logic [23:0] exp);
        @(negedge clk);
        pos_x = x;
        pos_y = y;
        de_in = de;
        @(negedge clk);
        de_in = 1'b0;
        @(negedge clk);
        check(tag, {8'b0, rgb_out}, {8'b0, exp});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        pos_x     = '0;
        pos_y     = '0;
        de_in     = 1'b0;
        hsync_in  = 1'b0;
        vsync_in  = 1'b0;
        cfg_valid = 1'b0;
        cfg_idx   = '0;
        cfg_x     = '0;
        cfg_y     = '0;
        cfg_w     = '0;
        cfg_h     = '0;
        cfg_mode  = '0;
        cfg_color = '0;
        bg_color  = BG;

        repeat (2) @(negedge clk);
        check("rst_rgb",       {8'b0, rgb_out}, 32'd0);
        check("rst_de",        {31'b0, de_out}, 32'd0);
        check("rst_hsync",     {31'b0, hsync_out}, 32'd0);
        check("rst_vsync",     {31'b0, vsync_out}, 32'd0);
        check("rst_cfg_ready", {31'b0, cfg_ready}, 32'd0);
        rst = 1'b0;
        #1 check("cfg_ready_idle", {31'b0, cfg_ready}, 32'd1);

        // Sync pass-through latency: one-cycle hsync pulse shows up 2 cycles later.
        @(negedge clk) hsync_in = 1'b1;
        @(negedge clk) hsync_in = 1'b0;
        check("hsync_not_at_1", {31'b0, hsync_out}, 32'd0);
        @(negedge clk);
        check("hsync_at_2", {31'b0, hsync_out}, 32'd1);

        // Basic fill, visible only after commit.
        cfg_write(2'd0, 12'd10, 12'd20, 12'd4, 12'd3, 2'd1, RED);
        pixel("fill_precommit", 12'd10, 12'd20, 1'b1, BG);
        vsync_pulse();
        pixel("fill_10_20", 12'd10, 12'd20, 1'b1, RED);
        pixel("fill_13_22", 12'd13, 12'd22, 1'b1, RED);
        pixel("fill_14_20", 12'd14, 12'd20, 1'b1, BG);
        pixel("fill_10_23", 12'd10, 12'd23, 1'b1, BG);
        pixel("fill_de0",   12'd10, 12'd20, 1'b0, 24'h000000);

        // Deferred commit.
        cfg_write(2'd0, 12'd10, 12'd20, 12'd4, 12'd3, 2'd1, GREEN);
        pixel("defer_still_red", 12'd11, 12'd21, 1'b1, RED);
        vsync_pulse();
        pixel("defer_now_green", 12'd11, 12'd21, 1'b1, GREEN);

        // Priority and outline.
        cfg_write(2'd0, 12'd0, 12'd0, 12'd5, 12'd5, 2'd2, BLUE);
        cfg_write(2'd1, 12'd0, 12'd0, 12'd8, 12'd8, 2'd1, WHITE);
        vsync_pulse();
        pixel("prio_0_0", 12'd0, 12'd0, 1'b1, BLUE);
        pixel("prio_2_2", 12'd2, 12'd2, 1'b1, WHITE);
        pixel("prio_4_4", 12'd4, 12'd4, 1'b1, BLUE);
        pixel("prio_4_2", 12'd4, 12'd2, 1'b1, BLUE);
        pixel("prio_6_6", 12'd6, 12'd6, 1'b1, WHITE);

        // Boundaries: zero width and a span ending at the coordinate limit.
        cfg_write(2'd0, 12'd0, 12'd0, 12'd0, 12'd0, 2'd0, 24'h0);
        cfg_write(2'd1, 12'd0, 12'd0, 12'd0, 12'd0, 2'd0, 24'h0);
        cfg_write(2'd2, 12'd100, 12'd0, 12'd0, 12'd5, 2'd1, 24'hAAAAAA);
        cfg_write(2'd3, 12'hFFE, 12'd0, 12'd4, 12'd2, 2'd1, GREY);
        vsync_pulse();
        pixel("w0_no_hit",  12'd100, 12'd0, 1'b1, BG);
        pixel("edge_FFE",   12'hFFE, 12'd0, 1'b1, GREY);
        pixel("edge_FFF",   12'hFFF, 12'd1, 1'b1, GREY);
        pixel("edge_FFD",   12'hFFD, 12'd0, 1'b1, BG);
        pixel("nowrap_0",   12'd0,   12'd0, 1'b1, BG);
        pixel("nowrap_1",   12'd1,   12'd0, 1'b1, BG);
        pixel("edge_y2",    12'hFFE, 12'd2, 1'b1, BG);

        // Mid-frame reset between clock edges.
        @(negedge clk);
        pos_x = 12'hFFE;
        pos_y = 12'd0;
        de_in = 1'b1;
        repeat (2) @(negedge clk);
        check("prerst_rgb", {8'b0, rgb_out}, {8'b0, GREY});
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_rgb",       {8'b0, rgb_out}, 32'd0);
        check("midrst_de",        {31'b0, de_out}, 32'd0);
        check("midrst_cfg_ready", {31'b0, cfg_ready}, 32'd0);
        @(negedge clk) rst = 1'b0;
        repeat (2) @(negedge clk);
        check("postrst_bg", {8'b0, rgb_out}, {8'b0, BG});
        de_in = 1'b0;

        // Blink: counter is 0 after reset; each commit advances one frame.
        cfg_write(2'd0, 12'd50, 12'd50, 12'd2, 12'd2, 2'd3, CYAN);
        pixel("blink_f0", 12'd50, 12'd50, 1'b1, BG);
        vsync_pulse();
        pixel("blink_f1", 12'd51, 12'd51, 1'b1, BG);
        vsync_pulse();
        pixel("blink_f2", 12'd51, 12'd51, 1'b1, CYAN);
        vsync_pulse();
        pixel("blink_f3", 12'd50, 12'd50, 1'b1, CYAN);
        vsync_pulse();
        pixel("blink_f4", 12'd50, 12'd50, 1'b1, BG);
        vsync_pulse();
        pixel("blink_f5", 12'd50, 12'd51, 1'b1, BG);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
